pingpong_frame_buffer: RTL and testbench



---
 rtl/pingpong_frame_buffer.sv | 118 +++++++++++
 tb/tb_pingpong_frame_buffer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pingpong_frame_buffer.sv
// Multi-channel ping-pong frame buffer between the I2S capture/playback path and the chunk processor.
// Capture and playback use cur_bank. The processor reads and writes the opposite bank.
module pingpong_frame_buffer #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 24,
  parameter int DEPTH    = 64,
  parameter int PTR_W    = $clog2(DEPTH),
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [SAMPLE_W-1:0] in_sample,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out_sample,
  output logic [PTR_W-1:0]    frame_ptr,
  output logic                cur_bank,
  output logic                chunk_pulse,
  input  logic [CH_W-1:0]     proc_rd_ch,
  input  logic [PTR_W-1:0]    proc_rd_addr,
  output logic [SAMPLE_W-1:0] proc_rd_data,
  input  logic                proc_wr_en,
  input  logic [CH_W-1:0]     proc_wr_ch,
  input  logic [PTR_W-1:0]    proc_wr_addr,
  input  logic [SAMPLE_W-1:0] proc_wr_data,
  input  logic                proc_done,
  output logic                overrun,
  output logic                sync_err,
  input  logic                err_clr
);

  localparam int ADDR_W    = 1 + CH_W + PTR_W;
  localparam int RAM_WORDS = 1 << ADDR_W;
  localparam logic [CH_W:0]    NUM_CH_EXT = (CH_W + 1)'(NUM_CH);
  localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);
  localparam logic [PTR_W-1:0] LAST_FRAME = PTR_W'(DEPTH - 1);

  logic [SAMPLE_W-1:0] in_ram  [RAM_WORDS];
  logic [SAMPLE_W-1:0] out_ram [RAM_WORDS];

  logic [CH_W-1:0]   exp_ch;
  logic              busy;
  logic              primed;

  logic              ch_ok;
  logic              accept;
  logic              frame_end;
  logic              boundary;
  logic              seq_err;
  logic              busy_left;
  logic              wr_ok;
  logic [ADDR_W-1:0] cap_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  always_comb begin
    ch_ok     = ({1'b0, in_ch} < NUM_CH_EXT);
    accept    = in_valid && ch_ok;
    frame_end = accept && (in_ch == LAST_CH);
    boundary  = frame_end && (frame_ptr == LAST_FRAME);
    seq_err   = in_valid && (!ch_ok || (in_ch != exp_ch));
    // A done strobe in the boundary cycle is credited before the busy check.
    busy_left = busy && !proc_done;
    wr_ok     = proc_wr_en && ({1'b0, proc_wr_ch} < NUM_CH_EXT);
    cap_addr  = {cur_bank, in_ch, frame_ptr};
    rd_addr   = {~cur_bank, proc_rd_ch, proc_rd_addr};
    wr_addr   = {~cur_bank, proc_wr_ch, proc_wr_addr};
  end

  // Sample storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (accept) in_ram[cap_addr] <= in_sample;
    if (wr_ok) out_ram[wr_addr] <= proc_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_sample   <= '0;
      proc_rd_data <= '0;
    end else begin
      out_valid    <= accept;
      out_sample   <= (accept && primed) ? out_ram[cap_addr] : '0;
      proc_rd_data <= in_ram[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_ptr   <= '0;
      cur_bank    <= 1'b0;
      chunk_pulse <= 1'b0;
      exp_ch      <= '0;
      busy        <= 1'b0;
      primed      <= 1'b0;
      overrun     <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      chunk_pulse <= boundary;
      if (accept) exp_ch <= (in_ch == LAST_CH) ? '0 : in_ch + 1'b1;
      if (frame_end) frame_ptr <= boundary ? '0 : frame_ptr + 1'b1;
      if (boundary) begin
        cur_bank <= ~cur_bank;
        primed   <= 1'b1;
        busy     <= 1'b1;
      end else if (proc_done) begin
        busy <= 1'b0;
      end
      // A new error beats a simultaneous clear.
      if (boundary && busy_left) overrun <= 1'b1;
      else if (err_clr)          overrun <= 1'b0;
      if (seq_err)      sync_err <= 1'b1;
      else if (err_clr) sync_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Directed bench for pingpong_frame_buffer with NUM_CH=2, DEPTH=4, SAMPLE_W=24.
// CH_W is widened to 2 so that an illegal channel number can be driven.
module tb_pingpong_frame_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  in_ch;
  logic [23:0] in_sample;
  logic        out_valid;
  logic [23:0] out_sample;
  logic [1:0]  frame_ptr;
  logic        cur_bank;
  logic        chunk_pulse;
  logic [1:0]  proc_rd_ch;
  logic [1:0]  proc_rd_addr;
  logic [23:0] proc_rd_data;
  logic        proc_wr_en;
  logic [1:0]  proc_wr_ch;
  logic [1:0]  proc_wr_addr;
  logic [23:0] proc_wr_data;
  logic        proc_done;
  logic        overrun;
  logic        sync_err;
  logic        err_clr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pingpong_frame_buffer #(
    .NUM_CH(2), .SAMPLE_W(24), .DEPTH(4), .PTR_W(2), .CH_W(2)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ch(in_ch), .in_sample(in_sample),
    .out_valid(out_valid), .out_sample(out_sample),
    .frame_ptr(frame_ptr), .cur_bank(cur_bank), .chunk_pulse(chunk_pulse),
    .proc_rd_ch(proc_rd_ch), .proc_rd_addr(proc_rd_addr), .proc_rd_data(proc_rd_data),
    .proc_wr_en(proc_wr_en), .proc_wr_ch(proc_wr_ch), .proc_wr_addr(proc_wr_addr),
    .proc_wr_data(proc_wr_data), .proc_done(proc_done),
    .overrun(overrun), .sync_err(sync_err), .err_clr(err_clr)
  );

  // Inputs change on the falling edge; results are inspected at the next falling edge.
  task automatic strobe(input logic [1:0] ch, input logic [23:0] val, input logic done, input logic clr);
    in_valid = 1'b1; in_ch = ch; in_sample = val; proc_done = done; err_clr = clr;
    @(negedge clk);
    in_valid = 1'b0; proc_done = 1'b0; err_clr = 1'b0;
  endtask

  task automatic idle(input logic done, input logic clr);
    proc_done = done; err_clr = clr;
    @(negedge clk);
    proc_done = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset out_valid: got %b want 0", out_valid); end
    vectors++; if (out_sample !== 24'd0) begin miscompares++; $display("[TB] FAIL reset out_sample: got %0d want 0", out_sample); end
    vectors++; if (frame_ptr !== 2'd0) begin miscompares++; $display("[TB] FAIL reset frame_ptr: got %0d want 0", frame_ptr); end
    vectors++; if (cur_bank !== 1'b0) begin miscompares++; $display("[TB] FAIL reset cur_bank: got %b want 0", cur_bank); end
    vectors++; if (chunk_pulse !== 1'b0) begin miscompares++; $display("[TB] FAIL reset chunk_pulse: got %b want 0", chunk_pulse); end
    vectors++; if ({overrun, sync_err} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset flags: got %b want 00", {overrun, sync_err}); end
    vectors++; if (proc_rd_data !== 24'd0) begin miscompares++; $display("[TB] FAIL reset proc_rd_data: got %0d want 0", proc_rd_data); end
  endtask

  // Chunk A: samples 1..8, ch0/ch1 interleaved, into bank 0.
  task automatic test_basic_capture;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] exp_fp;
      exp_fp = 2'(((i + 1) / 2) % 4);
      strobe(2'(i % 2), 24'(i + 1), 1'b0, 1'b0);
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL capture out_valid strobe %0d: got %b want 1", i, out_valid); end
      vectors++; if (out_sample !== 24'd0) begin miscompares++; $display("[TB] FAIL capture out_sample strobe %0d: got %0d want 0", i, out_sample); end
      vectors++; if (frame_ptr !== exp_fp) begin miscompares++; $display("[TB] FAIL capture frame_ptr strobe %0d: got %0d want %0d", i, frame_ptr, exp_fp); end
      vectors++; if (chunk_pulse !== (i == 7)) begin miscompares++; $display("[TB] FAIL capture chunk_pulse strobe %0d: got %b want %b", i, chunk_pulse, (i == 7)); end
      vectors++; if (cur_bank !== (i == 7)) begin miscompares++; $display("[TB] FAIL capture cur_bank strobe %0d: got %b want %b", i, cur_bank, (i == 7)); end
    end
    idle(1'b0, 1'b0);
    vectors++; if (chunk_pulse !== 1'b0) begin miscompares++; $display("[TB] FAIL capture chunk_pulse width: got %b want 0", chunk_pulse); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL capture out_valid idle: got %b want 0", out_valid); end
  endtask

  task automatic test_proc_read;
    proc_rd_ch = 2'd1; proc_rd_addr = 2'd2;
    @(negedge clk);
    vectors++; if (proc_rd_data !== 24'd6) begin miscompares++; $display("[TB] FAIL read ch1/2: got %0d want 6", proc_rd_data); end
    proc_rd_ch = 2'd0; proc_rd_addr = 2'd0;
    @(negedge clk);
    vectors++; if (proc_rd_data !== 24'd1) begin miscompares++; $display("[TB] FAIL read ch0/0: got %0d want 1", proc_rd_data); end
    proc_rd_ch = 2'd1; proc_rd_addr = 2'd3;
    @(negedge clk);
    vectors++; if (proc_rd_data !== 24'd8) begin miscompares++; $display("[TB] FAIL read ch1/3: got %0d want 8", proc_rd_data); end
  endtask

  task automatic test_loopback;
    logic [23:0] d;
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < 4; a++) begin
        proc_rd_ch = 2'(c); proc_rd_addr = 2'(a);
        @(negedge clk);
        d = proc_rd_data;
        vectors++; if (d !== 24'(2 * a + c + 1)) begin miscompares++; $display("[TB] FAIL loop read ch%0d/%0d: got %0d want %0d", c, a, d, 2 * a + c + 1); end
        proc_wr_en = 1'b1; proc_wr_ch = 2'(c); proc_wr_addr = 2'(a); proc_wr_data = d * 24'd2;
        @(negedge clk);
        proc_wr_en = 1'b0;
      end
    end
    idle(1'b1, 1'b0);
    // Chunk B plays back the never-written bank 1, so only valid is checked.
    for (int i = 0; i < 8; i++) begin
      strobe(2'(i % 2), 24'(11 + i), 1'b0, 1'b0);
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL chunkB out_valid strobe %0d: got %b want 1", i, out_valid); end
    end
    vectors++; if (cur_bank !== 1'b0) begin miscompares++; $display("[TB] FAIL chunkB cur_bank: got %b want 0", cur_bank); end
    idle(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      strobe(2'(i % 2), 24'(21 + i), 1'b0, 1'b0);
      vectors++; if (out_sample !== 24'(2 * (i + 1))) begin miscompares++; $display("[TB] FAIL loopback out_sample strobe %0d: got %0d want %0d", i, out_sample, 2 * (i + 1)); end
    end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL loopback overrun: got %b want 0", overrun); end
  endtask

  task automatic test_overrun;
    // Busy since the previous boundary; this chunk ends with no done strobe.
    for (int i = 0; i < 8; i++) begin
      strobe(2'(i % 2), 24'(31 + i), 1'b0, 1'b0);
      vectors++; if (overrun !== (i == 7)) begin miscompares++; $display("[TB] FAIL overrun strobe %0d: got %b want %b", i, overrun, (i == 7)); end
    end
    repeat (3) idle(1'b0, 1'b0);
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("[TB] FAIL overrun sticky: got %b want 1", overrun); end
    idle(1'b0, 1'b1);
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL overrun clear: got %b want 0", overrun); end
    for (int i = 0; i < 8; i++) strobe(2'(i % 2), 24'(51 + i), (i == 7), 1'b0);
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL overrun done-at-boundary: got %b want 0", overrun); end
    // Busy must have ended at 1, and a new overrun beats a simultaneous clear.
    for (int i = 0; i < 8; i++) strobe(2'(i % 2), 24'(61 + i), 1'b0, (i == 7));
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("[TB] FAIL overrun vs clear: got %b want 1", overrun); end
    idle(1'b1, 1'b1);
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL overrun final clear: got %b want 0", overrun); end
  endtask

  task automatic test_sync_err;
    vectors++; if (sync_err !== 1'b0) begin miscompares++; $display("[TB] FAIL sync idle: got %b want 0", sync_err); end
    strobe(2'd0, 24'd71, 1'b0, 1'b0);
    vectors++; if (sync_err !== 1'b0) begin miscompares++; $display("[TB] FAIL sync first ch0: got %b want 0", sync_err); end
    strobe(2'd0, 24'd72, 1'b0, 1'b0);
    vectors++; if (sync_err !== 1'b1) begin miscompares++; $display("[TB] FAIL sync repeat ch0: got %b want 1", sync_err); end
    vectors++; if (frame_ptr !== 2'd0) begin miscompares++; $display("[TB] FAIL sync frame_ptr after ch0: got %0d want 0", frame_ptr); end
    idle(1'b0, 1'b1);
    vectors++; if (sync_err !== 1'b0) begin miscompares++; $display("[TB] FAIL sync clear: got %b want 0", sync_err); end
    strobe(2'd1, 24'd73, 1'b0, 1'b0);
    vectors++; if (sync_err !== 1'b0) begin miscompares++; $display("[TB] FAIL sync resync ch1: got %b want 0", sync_err); end
    vectors++; if (frame_ptr !== 2'd1) begin miscompares++; $display("[TB] FAIL sync frame_ptr after ch1: got %0d want 1", frame_ptr); end
    strobe(2'd3, 24'd74, 1'b0, 1'b0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL sync bad ch out_valid: got %b want 0", out_valid); end
    vectors++; if (frame_ptr !== 2'd1) begin miscompares++; $display("[TB] FAIL sync bad ch frame_ptr: got %0d want 1", frame_ptr); end
    vectors++; if (sync_err !== 1'b1) begin miscompares++; $display("[TB] FAIL sync bad ch flag: got %b want 1", sync_err); end
  endtask

  task automatic test_reset_mid_chunk;
    for (int i = 0; i < 5; i++) strobe(2'(i % 2), 24'(81 + i), 1'b0, 1'b0);
    proc_rd_ch = 2'd0; proc_rd_addr = 2'd1;
    rst = 1'b1; in_valid = 1'b1; in_ch = 2'd1; in_sample = 24'd99;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    vectors++; if ({out_valid, chunk_pulse, cur_bank, overrun, sync_err} !== 5'b0) begin miscompares++; $display("[TB] FAIL midrst flags: got %b want 00000", {out_valid, chunk_pulse, cur_bank, overrun, sync_err}); end
    vectors++; if (frame_ptr !== 2'd0) begin miscompares++; $display("[TB] FAIL midrst frame_ptr: got %0d want 0", frame_ptr); end
    vectors++; if ({out_sample, proc_rd_data} !== 48'd0) begin miscompares++; $display("[TB] FAIL midrst data: got %0d/%0d want 0/0", out_sample, proc_rd_data); end
    // Output bank 0 still holds loopback data; playback must stay muted until primed again.
    for (int i = 0; i < 8; i++) begin
      strobe(2'(i % 2), 24'(91 + i), 1'b0, 1'b0);
      vectors++; if (chunk_pulse !== (i == 7)) begin miscompares++; $display("[TB] FAIL midrst chunk_pulse strobe %0d: got %b want %b", i, chunk_pulse, (i == 7)); end
      vectors++; if (out_sample !== 24'd0) begin miscompares++; $display("[TB] FAIL midrst out_sample strobe %0d: got %0d want 0", i, out_sample); end
    end
    vectors++; if (cur_bank !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst cur_bank: got %b want 1", cur_bank); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_sample = '0;
    proc_rd_ch = '0; proc_rd_addr = '0; proc_wr_en = 1'b0; proc_wr_ch = '0;
    proc_wr_addr = '0; proc_wr_data = '0; proc_done = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    test_reset;
    test_basic_capture;
    test_proc_read;
    test_loopback;
    test_overrun;
    test_sync_err;
    test_reset_mid_chunk;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
